// File: rtl/svpwm_phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : svpwm_phase_sequencer_if
// Description : Valid/ready load port carrying sector and dwell times for one
//               switching period.
// Revision    : 1.0 - initial release
// ============================================================================
interface svpwm_phase_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             LOAD_VALID;
    logic             LOAD_READY;
    logic [2:0]       LOAD_SECTOR;
    logic [CNT_W-1:0] LOAD_PERIOD;
    logic [CNT_W-1:0] LOAD_T1;
    logic [CNT_W-1:0] LOAD_T2;

    modport master (
        output LOAD_VALID, LOAD_SECTOR, LOAD_PERIOD, LOAD_T1, LOAD_T2,
        input  LOAD_READY
    );

    modport slave (
        input  LOAD_VALID, LOAD_SECTOR, LOAD_PERIOD, LOAD_T1, LOAD_T2,
        output LOAD_READY
    );
endinterface
`default_nettype wire

// File: rtl/svpwm_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : svpwm_phase_sequencer
// Description : Plays a zero / first-active / second-active / zero vector
//               sequence over each switching period, with sector and dwell
//               times taken from a double-buffered load port.
// Revision    : 1.0 - initial release
// ============================================================================
module svpwm_phase_sequencer #(
    parameter int CNT_W          = 16,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  wire                    CLK,
    input  wire                    RST,
    input  wire                    EN,
    input  wire                    ERR_CLR,
    svpwm_phase_sequencer_if.slave load,
    output logic [2:0]             SECTOR,
    output logic                   U_0,
    output logic                   U_1,
    output logic                   U_2,
    output logic                   PERIOD_START,
    output logic                   ERR
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ZERO_A = 3'd1,
        ST_ACT_1  = 3'd2,
        ST_ACT_2  = 3'd3,
        ST_ZERO_B = 3'd4
    } state_t;

    // Dwells are pre-split at load time so the boundary path needs no subtractor.
    typedef struct packed {
        logic [2:0]       sector;
        logic [CNT_W-1:0] z0;
        logic [CNT_W-1:0] t1;
        logic [CNT_W-1:0] t2;
        logic [CNT_W-1:0] zb;
    } slot_t;

    localparam logic [CNT_W-1:0] c_def_period = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] c_def_z0     = c_def_period >> 1;
    localparam logic [CNT_W-1:0] c_def_zb     = c_def_period - c_def_z0;
    localparam slot_t            c_def_slot   = {3'd0, c_def_z0, {CNT_W{1'b0}},
                                                 {CNT_W{1'b0}}, c_def_zb};

    function automatic logic [CNT_W-1:0] f_dwell(input state_t s, input slot_t d);
        case (s)
            ST_ZERO_A: f_dwell = d.z0;
            ST_ACT_1:  f_dwell = d.t1;
            ST_ACT_2:  f_dwell = d.t2;
            ST_ZERO_B: f_dwell = d.zb;
            default:   f_dwell = '0;
        endcase
    endfunction

    // First phase after s with a nonzero dwell; ST_IDLE means the period is over.
    function automatic state_t f_next_phase(input state_t s, input slot_t d);
        f_next_phase = ST_IDLE;
        if (s == ST_IDLE && d.z0 != '0)
            f_next_phase = ST_ZERO_A;
        else if (s <= ST_ZERO_A && d.t1 != '0)
            f_next_phase = ST_ACT_1;
        else if (s <= ST_ACT_1 && d.t2 != '0)
            f_next_phase = ST_ACT_2;
        else if (s <= ST_ACT_2 && d.zb != '0)
            f_next_phase = ST_ZERO_B;
    endfunction

    state_t           r_state, w_state_nxt, w_phase_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    slot_t            r_shadow, w_shadow_nxt;
    slot_t            r_pend, w_pend_nxt;
    slot_t            w_src, w_load_slot;
    logic             r_ready, w_ready_nxt;
    logic             r_err, w_err_nxt;
    logic [2:0]       r_sector, w_sector_nxt;
    logic             r_u0, r_u1, r_u2, r_ps;
    logic             w_start, w_fire, w_load_ok;
    logic [CNT_W:0]   w_dwell_sum;
    logic [CNT_W-1:0] w_t0;

    always_comb begin
        w_dwell_sum = {1'b0, load.LOAD_T1} + {1'b0, load.LOAD_T2};
        w_load_ok   = (load.LOAD_SECTOR <= 3'd5) && (load.LOAD_PERIOD != '0) &&
                      (w_dwell_sum <= {1'b0, load.LOAD_PERIOD});
        w_fire      = load.LOAD_VALID && r_ready;
        w_t0        = load.LOAD_PERIOD - load.LOAD_T1 - load.LOAD_T2;
        w_load_slot = {load.LOAD_SECTOR, w_t0 >> 1, load.LOAD_T1, load.LOAD_T2,
                       w_t0 - (w_t0 >> 1)};
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_start      = 1'b0;
        w_src        = r_ready ? r_shadow : r_pend;
        w_phase_nxt  = f_next_phase(r_state, r_shadow);

        if (r_state == ST_IDLE) begin
            w_start = EN;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_phase_nxt != ST_IDLE) begin
            w_state_nxt = w_phase_nxt;
            w_cnt_nxt   = f_dwell(w_phase_nxt, r_shadow) - CNT_W'(1);
        end else if (EN) begin
            w_start = 1'b1;
        end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end

        // A load landing in this same cycle only reaches pending, not the shadow.
        if (w_start) begin
            w_shadow_nxt = w_src;
            w_state_nxt  = f_next_phase(ST_IDLE, w_src);
            w_cnt_nxt    = f_dwell(w_state_nxt, w_src) - CNT_W'(1);
        end

        w_pend_nxt  = r_pend;
        w_ready_nxt = r_ready;
        if (w_fire && w_load_ok) begin
            w_pend_nxt  = w_load_slot;
            w_ready_nxt = 1'b0;
        end else if (w_start) begin
            w_ready_nxt = 1'b1;
        end

        w_err_nxt = r_err;
        if (w_fire && !w_load_ok)
            w_err_nxt = 1'b1;
        else if (ERR_CLR)
            w_err_nxt = 1'b0;

        w_sector_nxt = w_start ? w_src.sector : r_sector;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= c_def_slot;
            r_pend   <= c_def_slot;
            r_ready  <= 1'b1;
            r_err    <= 1'b0;
            r_sector <= 3'd0;
            r_u0     <= 1'b1;
            r_u1     <= 1'b0;
            r_u2     <= 1'b0;
            r_ps     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_pend   <= w_pend_nxt;
            r_ready  <= w_ready_nxt;
            r_err    <= w_err_nxt;
            r_sector <= w_sector_nxt;
            r_u0     <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ZERO_A) ||
                        (w_state_nxt == ST_ZERO_B);
            r_u1     <= (w_state_nxt == ST_ACT_1);
            r_u2     <= (w_state_nxt == ST_ACT_2);
            r_ps     <= w_start;
        end
    end

    assign load.LOAD_READY = r_ready;
    assign SECTOR          = r_sector;
    assign U_0             = r_u0;
    assign U_1             = r_u1;
    assign U_2             = r_u2;
    assign PERIOD_START    = r_ps;
    assign ERR             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_svpwm_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_svpwm_phase_sequencer
// Description : Directed bench for svpwm_phase_sequencer with hand-computed
//               per-cycle phase patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_svpwm_phase_sequencer;

    localparam int c_cnt_w = 16;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       ERR_CLR;
    logic [2:0] SECTOR;
    logic       U_0, U_1, U_2, PERIOD_START, ERR;

    int n_checks = 0;
    int n_fail   = 0;

    svpwm_phase_sequencer_if #(.CNT_W(c_cnt_w)) load_if ();

    svpwm_phase_sequencer #(
        .CNT_W          (c_cnt_w),
        .DEFAULT_PERIOD (10)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .EN           (EN),
        .ERR_CLR      (ERR_CLR),
        .load         (load_if),
        .SECTOR       (SECTOR),
        .U_0          (U_0),
        .U_1          (U_1),
        .U_2          (U_2),
        .PERIOD_START (PERIOD_START),
        .ERR          (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_outs(input string tag, input logic [2:0] u_exp,
                              input logic ps_exp, input logic [2:0] sec_exp);
        check_eq({tag, ".u"}, {U_2, U_1, U_0}, u_exp);
        check_eq({tag, ".ps"}, PERIOD_START, ps_exp);
        check_eq({tag, ".sec"}, SECTOR, sec_exp);
    endtask

    // pat: per-k phase ('0','1','2'); rdy: per-k LOAD_READY ('0','1','-').
    task automatic check_period(input string tag, input string pat, input logic [2:0] sec,
                                input string rdy, input int k_from, input int k_to);
        for (int k = k_from; k < k_to; k++) begin
            logic [2:0] u;
            u = (pat[k] == "1") ? 3'b010 : (pat[k] == "2") ? 3'b100 : 3'b001;
            check_outs($sformatf("%s.k%0d", tag, k), u, (k == 0), sec);
            if (rdy[k] != "-")
                check_eq($sformatf("%s.rdy%0d", tag, k), load_if.LOAD_READY, (rdy[k] == "1"));
            step();
        end
    endtask

    task automatic set_load(input logic v, input logic [2:0] sec, input logic [15:0] p,
                            input logic [15:0] t1, input logic [15:0] t2);
        load_if.LOAD_VALID  = v;
        load_if.LOAD_SECTOR = sec;
        load_if.LOAD_PERIOD = p;
        load_if.LOAD_T1     = t1;
        load_if.LOAD_T2     = t2;
    endtask

    // Holds VALID until a cycle with READY high has been clocked.
    task automatic drive_load(input logic [2:0] sec, input logic [15:0] p,
                              input logic [15:0] t1, input logic [15:0] t2);
        logic r;
        logic done;
        done = 1'b0;
        set_load(1'b1, sec, p, t1, t2);
        for (int i = 0; i < 50 && !done; i++) begin
            r = load_if.LOAD_READY;
            @(negedge CLK);
            done = r;
        end
        load_if.LOAD_VALID = 1'b0;
        check_eq("load_handshake", done, 1'b1);
    endtask

    task automatic pulse_load(input logic [2:0] sec, input logic [15:0] p,
                              input logic [15:0] t1, input logic [15:0] t2, input logic clr);
        set_load(1'b1, sec, p, t1, t2);
        ERR_CLR = clr;
        step();
        load_if.LOAD_VALID = 1'b0;
        ERR_CLR = 1'b0;
    endtask

    task automatic pulse_clr();
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        EN = 1'b1;
        ERR_CLR = 1'b0;
        set_load(1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
        step();
        check_outs("rst", 3'b001, 1'b0, 3'd0);
        check_eq("rst.err", ERR, 1'b0);
        check_eq("rst.rdy", load_if.LOAD_READY, 1'b1);
        RST = 1'b0;
        step();

        check_period("def0", "0000000000", 3'd0, "1111111111", 0, 10);
        fork drive_load(3'd2, 16'd10, 16'd3, 16'd2); join_none
        check_period("def1", "0000000000", 3'd0, "1000000000", 0, 10);
        check_period("a0", "0011122000", 3'd2, "1111111111", 0, 10);
        fork drive_load(3'd4, 16'd8, 16'd0, 16'd8); join_none
        check_period("a1", "0011122000", 3'd2, "1000000000", 0, 10);
        fork drive_load(3'd5, 16'd8, 16'd0, 16'd0); join_none
        check_period("t2all", "22222222", 3'd4, "10000000", 0, 8);
        check_period("zall", "00000000", 3'd5, "11111111", 0, 8);

        pulse_load(3'd1, 16'd10, 16'd6, 16'd5, 1'b0);
        check_eq("rej_sum.err", ERR, 1'b1);
        check_eq("rej_sum.rdy", load_if.LOAD_READY, 1'b1);
        pulse_clr();
        check_eq("clr.err", ERR, 1'b0);
        pulse_load(3'd6, 16'd10, 16'd1, 16'd1, 1'b0);
        check_eq("rej_sec.err", ERR, 1'b1);
        check_eq("rej_sec.rdy", load_if.LOAD_READY, 1'b1);
        pulse_load(3'd1, 16'd10, 16'd6, 16'd5, 1'b1);
        check_eq("rej_vs_clr.err", ERR, 1'b1);
        pulse_clr();
        check_eq("clr2.err", ERR, 1'b0);
        pulse_load(3'd1, 16'd10, 16'hFFFF, 16'd2, 1'b0);
        check_eq("rej_wrap.err", ERR, 1'b1);
        check_eq("rej_wrap.rdy", load_if.LOAD_READY, 1'b1);
        check_period("zrej", "00000000", 3'd5, "11111111", 6, 8);
        check_period("zkeep", "00000000", 3'd5, "11111111", 0, 8);

        fork
            begin
                drive_load(3'd1, 16'd10, 16'd1, 16'd4);
                drive_load(3'd3, 16'd6, 16'd2, 16'd2);
            end
        join_none
        check_period("stall", "00000000", 3'd5, "10000000", 0, 8);
        check_period("d", "0012222000", 3'd1, "1000000000", 0, 10);
        fork drive_load(3'd2, 16'd10, 16'd3, 16'd2); join_none
        check_period("e", "011220", 3'd3, "100000", 0, 6);
        fork drive_load(3'd3, 16'd6, 16'd2, 16'd2); join_none
        check_period("a2", "0011122000", 3'd2, "1000000000", 0, 4);

        RST = 1'b1;
        step();
        RST = 1'b0;
        check_outs("rstmid", 3'b001, 1'b0, 3'd0);
        check_eq("rstmid.err", ERR, 1'b0);
        check_eq("rstmid.rdy", load_if.LOAD_READY, 1'b1);
        step();
        fork drive_load(3'd4, 16'd10, 16'd2, 16'd6); join_none
        check_period("rdef", "0000000000", 3'd0, "1000000000", 0, 10);

        check_period("f", "0112222220", 3'd4, "1111111111", 0, 3);
        EN = 1'b0;
        check_period("fend", "0112222220", 3'd4, "1111111111", 3, 10);
        check_outs("idle0", 3'b001, 1'b0, 3'd4);
        pulse_load(3'd0, 16'd1, 16'd1, 16'd0, 1'b0);
        check_outs("idle1", 3'b001, 1'b0, 3'd4);
        check_eq("idle1.rdy", load_if.LOAD_READY, 1'b0);
        step();
        check_outs("idle2", 3'b001, 1'b0, 3'd4);
        EN = 1'b1;
        step();
        fork drive_load(3'd5, 16'd1, 16'd0, 16'd0); join_none
        check_period("p1a", "1", 3'd0, "1", 0, 1);
        check_period("p1b", "1", 3'd0, "0", 0, 1);
        check_period("p1c", "0", 3'd5, "1", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
